// File: rtl/gift_inv_sbox_seq.sv
// gift_inv_sbox_seq -- GIFT-128 inverse S-box layer, sequential datapath.
//
// Applies the GIFT inverse S-box to all 32 nibbles of a 128-bit state.
// Nibble positions are unchanged. The default build substitutes one 32-bit lane
// (8 nibbles) per cycle and needs 4 cycles per state. Defining the macro
// GIFT_INV_SBOX_FAST_EN substitutes all 32 nibbles in one cycle instead.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   upstream state available
//   in_ready   block accepts a state this cycle (IDLE only)
//   in_data    128-bit input state; nibble i = bits [4i+3:4i]
//   out_valid  out_data holds a completed result (DONE only)
//   out_ready  downstream consumes the result
//   out_data   128-bit state after the inverse S-box layer
//   busy       high while in BUSY
module gift_inv_sbox_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int unsigned STATE_W = 128;
    localparam int unsigned NIB_W   = 4;
`ifndef GIFT_INV_SBOX_FAST_EN
    localparam int unsigned LANES        = 4;
    localparam int unsigned LANE_W       = 32;
    localparam int unsigned NIB_PER_LANE = LANE_W / NIB_W;
`endif
    localparam int unsigned NIBS    = STATE_W / NIB_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [STATE_W-1:0] work_q, work_d;
    logic               in_ready_d, out_valid_d, busy_d;

    // GIFT inverse S-box table
    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hD;
            4'h1: y = 4'h0;
            4'h2: y = 4'h8;
            4'h3: y = 4'h6;
            4'h4: y = 4'h2;
            4'h5: y = 4'hC;
            4'h6: y = 4'h4;
            4'h7: y = 4'hB;
            4'h8: y = 4'hE;
            4'h9: y = 4'h7;
            4'hA: y = 4'h1;
            4'hB: y = 4'hA;
            4'hC: y = 4'h3;
            4'hD: y = 4'h9;
            4'hE: y = 4'hF;
            default: y = 4'h5;
        endcase
        return y;
    endfunction

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
`ifdef GIFT_INV_SBOX_FAST_EN
                for (int n = 0; n < int'(NIBS); n++) begin
                    work_d[NIB_W*n +: NIB_W] = inv_sbox(work_q[NIB_W*n +: NIB_W]);
                end
                cnt_d   = '0;
                state_d = DONE;
`else
                // Only the lane selected by the counter is substituted
                for (int l = 0; l < int'(LANES); l++) begin
                    if (cnt_q == 2'(l)) begin
                        for (int j = 0; j < int'(NIB_PER_LANE); j++) begin
                            work_d[LANE_W*l + NIB_W*j +: NIB_W] =
                                inv_sbox(work_q[LANE_W*l + NIB_W*j +: NIB_W]);
                        end
                    end
                end
                // 3 -> 0 wrap happens only here, on the lane-3 edge
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'(LANES - 1)) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == BUSY);
    end

    // State and output registers; reset wins over any handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            work_q    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
        end
    end

    assign out_data = work_q;

endmodule

// File: tb/tb_gift_inv_sbox_seq.sv
// tb_gift_inv_sbox_seq -- self-checking bench for gift_inv_sbox_seq.
// Directed vectors, stall/ignore behaviour, mid-operation reset, and 100 random
// states passed through a software GIFT-128 inverse permutation before the DUT.
module tb_gift_inv_sbox_seq;

`ifdef GIFT_INV_SBOX_FAST_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 4;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] INV_TBL [16] = '{4'hD, 4'h0, 4'h8, 4'h6, 4'h2, 4'hC, 4'h4, 4'hB,
                                           4'hE, 4'h7, 4'h1, 4'hA, 4'h3, 4'h9, 4'hF, 4'h5};

    gift_inv_sbox_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: inverse S-box on every nibble via table lookup
    function automatic logic [127:0] ref_inv_sbox(input logic [127:0] x);
        logic [127:0] y;
        for (int i = 0; i < 32; i++) y[4*i +: 4] = INV_TBL[x[4*i +: 4]];
        return y;
    endfunction

    // Software GIFT-128 inverse bit permutation: forward P moves bit i to P(i)
    function automatic logic [127:0] ref_inv_perm(input logic [127:0] x);
        logic [127:0] y;
        int p;
        for (int i = 0; i < 128; i++) begin
            p = 4 * (i / 16) + 32 * (((3 * ((i % 16) / 4)) + (i % 4)) % 4) + (i % 4);
            y[i] = x[p];
        end
        return y;
    endfunction

    // Send one state, measure latency, check result, then hand it off
    task automatic run_txn(input string tag, input logic [127:0] din,
                           input logic [127:0] exp, input int stall);
        int cyc;
        @(negedge clk);
        check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        in_data  = din;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~din;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 128'(cyc), 128'(LAT));
        check({tag, "_data"}, out_data, exp);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_handoff"}, 128'({out_valid, in_ready}), 128'(2'b01));
    endtask

    initial begin
        logic [127:0] held, st, pin;
        int cyc;

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_flags", 128'({in_ready, out_valid, busy}), 128'(3'b100));
        check("reset_data", out_data, 128'h0);

        // Directed vectors
        run_txn("zero", 128'h0, {32{4'hD}}, 0);
        run_txn("ones", {32{4'hF}}, {32{4'h5}}, 0);
        run_txn("ramp", 128'h0123456789ABCDEF0123456789ABCDEF,
                128'hD0862C4BE71A39F5D0862C4BE71A39F5, 0);

        // Busy indication right after accept
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 128'h1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_flags", 128'({in_ready, out_valid, busy}), 128'(3'b001));
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check("busy_latency", 128'(cyc), 128'(LAT));

        // Stall 10 cycles with in_valid driving changing data
        held = out_data;
        check("stall_start", held, ref_inv_sbox(128'h1));
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            @(negedge clk);
            check("stall_data", out_data, held);
            check("stall_flags", 128'({in_ready, out_valid, busy}), 128'(3'b010));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        // in_valid was high on the handshake edge: must not have been captured
        check("handshake_flags", 128'({in_ready, out_valid, busy}), 128'(3'b100));
        check("handshake_nocap", out_data, held);
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("delivered_once", 128'(out_valid), 128'(0));
        end

        // Reset on the 2nd BUSY edge
        in_valid = 1'b1;
        in_data  = 128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_flags", 128'({in_ready, out_valid, busy}), 128'(3'b100));
        check("midrst_data", out_data, 128'h0);
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            check("midrst_no_valid", 128'(out_valid), 128'(0));
        end
        run_txn("after_rst", 128'hFEDCBA9876543210_0F1E2D3C4B5A6978,
                ref_inv_sbox(128'hFEDCBA9876543210_0F1E2D3C4B5A6978), 1);

        // Random states through the software inverse permutation
        for (int t = 0; t < 100; t++) begin
            st  = {$urandom, $urandom, $urandom, $urandom};
            pin = ref_inv_perm(st);
            run_txn("random", pin, ref_inv_sbox(pin), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gift_inv_sbox_seq.md
GIFT_INV_SBOX_SEQ -- requirements
Module: gift_inv_sbox_seq

Interface
REQ-001 The block SHALL have one clock and synchronous active-high reset.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port rst, input, 1 bit: synchronous reset, active-high.
REQ-004 Port in_valid, input, 1 bit: upstream 128-bit state available.
REQ-005 Port in_ready, output, 1 bit: block accepts a state this cycle.
REQ-006 Port in_data, input, 128 bits: state from the GIFT-128 inverse bit-permutation stage; nibble i = bits [4i+3:4i].
REQ-007 Port out_valid, output, 1 bit: out_data holds a completed result.
REQ-008 Port out_ready, input, 1 bit: downstream consumes the result.
REQ-009 Port out_data, output, 128 bits: state after the inverse S-box layer.
REQ-010 Port busy, output, 1 bit: high while in state BUSY.

Function
REQ-011 The block SHALL apply the GIFT inverse S-box to all 32 nibbles; nibble position is unchanged.
REQ-012 Inverse S-box for inputs 0..F SHALL be D,0,8,6,2,C,4,B,E,7,1,A,3,9,F,5.
REQ-013 FSM states SHALL be IDLE, BUSY and DONE, plus a 2-bit lane counter.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; busy SHALL be 1 only in BUSY.
REQ-015 IDLE: on a clock edge with in_valid=1, the block SHALL capture in_data into the working register, clear the counter and go to BUSY.
REQ-016 BUSY: each edge SHALL substitute lane k (bits [32k+31:32k], 8 nibbles), where k is the counter value, and increment the counter.
REQ-017 BUSY: the edge that processes lane 3 SHALL move the FSM to DONE.
REQ-018 Latency SHALL be 4 cycles: out_valid rises 4 edges after the accept edge.
REQ-019 DONE: out_data and out_valid SHALL hold stable until an edge with out_ready=1, which returns the FSM to IDLE.
REQ-020 in_valid in BUSY or DONE SHALL be ignored; no input is captured and no state is corrupted.
REQ-021 A new input SHALL be accepted no earlier than the cycle after the output handshake.
REQ-022 out_data SHALL equal the working register; its value outside DONE is don't-care for consumers but deterministic.
REQ-023 Counter wrap from 3 to 0 SHALL occur only on the lane-3 edge.

Reset
REQ-024 On an edge with rst=1, the block SHALL reset regardless of state.
REQ-025 Reset SHALL set: FSM to IDLE, counter to 0, working register to 0, out_valid to 0, busy to 0, in_ready to 1 from the following cycle.
REQ-026 Reset mid-operation (BUSY or DONE) SHALL discard the in-flight state; no out_valid pulse follows.
REQ-027 rst SHALL take priority over in_valid and out_ready on the same edge.

Configuration
REQ-028 Macro GIFT_INV_SBOX_FAST_EN SHALL select the datapath width.
REQ-029 With GIFT_INV_SBOX_FAST_EN defined, all 32 nibbles SHALL be substituted on the first BUSY edge, which goes directly to DONE; latency is 1 cycle and the counter is unused (held 0).
REQ-030 Without GIFT_INV_SBOX_FAST_EN, the behaviour SHALL be the 4-lane iterative datapath of REQ-016..REQ-018.
REQ-031 In both builds, the handshake and reset behaviour SHALL be identical.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
- in_data=0x000…0 (all zero), out_ready=1 -> out_data=0xDDDD…D (32 D nibbles); out_valid 4 cycles after accept (1 cycle in FAST build).
- in_data=0xFFF…F -> out_data=0x555…5.
- in_data=0x0123456789ABCDEF0123456789ABCDEF -> out_data=0xD0862C4BE71A39F5D0862C4BE71A39F5.
- out_ready=0 for 10 cycles after out_valid, with in_valid=1 and changing in_data -> out_data is unchanged, in_ready=0, and the result is delivered once when out_ready=1.
- rst=1 on the 2nd BUSY edge -> next cycle in IDLE, in_ready=1, out_valid=0, working register 0; the next input is processed correctly.
- Chain gift_inv_perm to this block and compare 100 random states against a software inverse permutation plus inverse S-box model, with a zero mismatch count.
